alu_exec_unit: RTL and testbench

Iterative execute-stage ALU for the multi-cycle RISC2 core. It accepts an operation from the decode side as a 4-bit ALUControl code with two operands. It returns a registered ALUResult, Zero and Illegal flags over a valid/ready handshake. Logic and arithmetic ops finish in one cycle; shifts run one bit per cycle; MUL/MULH use a shift-add multiplier.

---
 rtl/alu_exec_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Iterative execute-stage ALU: single-cycle logic/arith, bit-serial shifts, shift-add MUL/MULH.
// Optional multiplier enabled by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1011;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULH = 4'b1001;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MUL, S_FIX, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t           state, state_d;
    logic [3:0]       op, op_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [SHW-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d, illegal_d, out_valid_d, in_ready_d;

    logic [WIDTH-1:0] simple_res;
    logic             is_shift, is_illegal;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] sh_next;
    logic             load_res, illegal_val;
    logic [WIDTH-1:0] res_val;
    logic             accept;

`ifdef ALU_EXEC_MUL_EN
    logic                 is_mul;
    logic [WIDTH-1:0]     mcand, mcand_d;
    logic [2*WIDTH-1:0]   prod, prod_d, prod_fix;
    logic                 sgn, sgn_d;
    logic [WIDTH:0]       mul_sum;
`endif

    assign accept = in_valid && in_ready;
    assign sh_amt = SrcB[SHW-1:0];

    // Decode the offered operation; unlisted codes (and X/Z) fall to illegal.
    always_comb begin
        simple_res = '0;
        is_shift   = 1'b0;
        is_illegal = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        is_mul     = 1'b0;
`endif
        case (ALUControl)
            OP_ADD:  simple_res = SrcA + SrcB;
            OP_SUB:  simple_res = SrcA - SrcB;
            OP_AND:  simple_res = SrcA & SrcB;
            OP_OR:   simple_res = SrcA | SrcB;
            OP_XOR:  simple_res = SrcA ^ SrcB;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL, OP_MULH: is_mul = 1'b1;
`endif
            default: is_illegal = 1'b1;
        endcase
    end

    // One-bit shift step; SRA replicates the MSB, which still holds SrcA's sign.
    always_comb begin
        case (op)
            OP_SLL:  sh_next = {shreg[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, shreg[WIDTH-1:1]};
            default: sh_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // Shift-add step on {hi, multiplier}: add multiplicand into hi when lsb set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_fix = sgn ? (~prod + (2*WIDTH)'(1)) : prod;
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        op_d        = op;
        shreg_d     = shreg;
        cnt_d       = cnt;
        result_d    = ALUResult;
        zero_d      = Zero;
        illegal_d   = Illegal;
        out_valid_d = out_valid;
        load_res    = 1'b0;
        res_val     = '0;
        illegal_val = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        mcand_d     = mcand;
        prod_d      = prod;
        sgn_d       = sgn;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_d = ALUControl;
                    if (is_shift) begin
                        if (sh_amt == '0) begin
                            load_res = 1'b1;
                            res_val  = SrcA;
                        end else begin
                            shreg_d = SrcA;
                            cnt_d   = sh_amt;
                            state_d = S_SHIFT;
                        end
`ifdef ALU_EXEC_MUL_EN
                    end else if (is_mul) begin
                        mcand_d = SrcA[WIDTH-1] ? (~SrcA + WIDTH'(1)) : SrcA;
                        prod_d  = {{WIDTH{1'b0}}, (SrcB[WIDTH-1] ? (~SrcB + WIDTH'(1)) : SrcB)};
                        sgn_d   = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                        cnt_d   = SHW'(WIDTH-1);
                        state_d = S_MUL;
`endif
                    end else begin
                        load_res    = 1'b1;
                        res_val     = simple_res;
                        illegal_val = is_illegal;
                    end
                end
            end
            S_SHIFT: begin
                shreg_d = sh_next;
                cnt_d   = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    load_res = 1'b1;
                    res_val  = sh_next;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            S_MUL: begin
                prod_d = {mul_sum, prod[WIDTH-1:1]};
                cnt_d  = cnt - SHW'(1);
                if (cnt == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                load_res = 1'b1;
                res_val  = (op == OP_MULH) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_res) begin
            result_d    = res_val;
            zero_d      = (res_val == '0);
            illegal_d   = illegal_val;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
        end
        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op        <= '0;
            shreg     <= '0;
            cnt       <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Illegal   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mcand     <= '0;
            prod      <= '0;
            sgn       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            op        <= op_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            ALUResult <= result_d;
            Zero      <= zero_d;
            Illegal   <= illegal_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
`ifdef ALU_EXEC_MUL_EN
            mcand     <= mcand_d;
            prod      <= prod_d;
            sgn       <= sgn_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corners, backpressure, mid-op reset, random ops vs model.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: result, illegal flag and latency straight from the opcode table.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (c)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: r = (a < b) ? 32'd1 : 32'd0;
            4'b1010: begin r = a << b[4:0]; lat = int'(b[4:0]) + 1; end
            4'b1100: begin r = a >> b[4:0]; lat = int'(b[4:0]) + 1; end
            4'b1011: begin r = 32'($signed(a) >>> b[4:0]); lat = int'(b[4:0]) + 1; end
`ifdef ALU_EXEC_MUL_EN
            4'b1000, 4'b1001: begin
                longint p;
                p   = longint'($signed(a)) * longint'($signed(b));
                r   = (c == 4'b1000) ? 32'(p) : 32'(p >>> 32);
                lat = WIDTH + 2;
            end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Offer one op at a negedge, accept on the next posedge, then scramble the inputs.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output logic to);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        to = !in_ready;
        ALUControl = c;
        SrcA = a;
        SrcB = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ALUControl = 4'($urandom);
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    // Count cycles from accept to out_valid; note whether in_ready rose while busy.
    task automatic wait_done(output int lat, output logic rdy_seen, output logic to);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        to = !out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ALUControl = '0;
        SrcA = '0;
        SrcB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (ALUResult !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", ALUResult); end
        checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", Zero); end
        checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", Illegal); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        vec_t dv [11];
        logic [31:0] er, gr;
        logic eil, gz, gil, to, rdy;
        int elat, glat;
        dv = '{
            '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001},
            '{4'b0001, 32'h0000_0005, 32'h0000_0005},
            '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001},
            '{4'b0111, 32'h1234_5678, 32'h9ABC_DEF0},
            '{4'b1011, 32'h8000_0000, 32'h0000_0004},
            '{4'b1010, 32'h1234_5678, 32'hFFFF_FFE0},
            '{4'b1100, 32'hFFFF_FFFF, 32'h0000_001F},
            '{4'b1000, 32'hFFFF_FFFE, 32'h0000_0003},
            '{4'b1001, 32'hFFFF_FFFE, 32'h0000_0003},
            '{4'b1001, 32'h8000_0000, 32'h8000_0000}
        };
        foreach (dv[i]) begin
            model(dv[i].c, dv[i].a, dv[i].b, er, eil, elat);
            issue(dv[i].c, dv[i].a, dv[i].b, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_accept_timeout: in_ready stayed %b expected 1", i, in_ready); end
            wait_done(glat, rdy, to);
            gr = ALUResult; gz = Zero; gil = Illegal;
            checks++; if (to) begin errors++; $display("FAIL dir%0d_done_timeout: out_valid %b expected 1", i, out_valid); end
            checks++; if (gr !== er) begin errors++; $display("FAIL dir%0d_result code=%b: got %h expected %h", i, dv[i].c, gr, er); end
            checks++; if (gz !== (er == 32'd0)) begin errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, gz, er == 32'd0); end
            checks++; if (gil !== eil) begin errors++; $display("FAIL dir%0d_illegal: got %b expected %b", i, gil, eil); end
            checks++; if (glat != elat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, glat, elat); end
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_in_ready: got %b expected 0", i, rdy); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic to, rdy;
        int glat;
        issue(4'b1100, 32'hF000_0000, 32'd3, to);
        wait_done(glat, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL bp_done_timeout: out_valid %b expected 1", out_valid); end
        ALUControl = 4'b0000;
        SrcA = 32'd10;
        SrcB = 32'd20;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || ALUResult !== 32'h1E00_0000 || Zero !== 1'b0 || Illegal !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%h z=%b il=%b rdy=%b expected v=1 r=1e000000 z=0 il=0 rdy=0",
                         k, out_valid, ALUResult, Zero, Illegal, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_handshake: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || ALUResult !== 32'd30) begin errors++; $display("FAIL bp_next_op: got v=%b r=%h expected v=1 r=0000001e", out_valid, ALUResult); end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic to;
        logic seen = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        issue(4'b1000, 32'hFFFF_FFFE, 32'd3, to);
`else
        issue(4'b1100, 32'hFFFF_FFFF, 32'd31, to);
`endif
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (ALUResult !== '0) begin errors++; $display("FAIL midrst_result: got %h expected 0", ALUResult); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b expected 1", in_ready); end
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result: got out_valid=%b expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] c;
        logic [31:0] a, b, er, gr;
        logic eil, gz, gil, to, rdy;
        int elat, glat;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) b = a;
            model(c, a, b, er, eil, elat);
            issue(c, a, b, to);
            wait_done(glat, rdy, to);
            gr = ALUResult; gz = Zero; gil = Illegal;
            checks++;
            if (to || gr !== er || gz !== (er == 32'd0) || gil !== eil || glat != elat || rdy !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d code=%b a=%h b=%h: got r=%h z=%b il=%b lat=%0d rdy=%b expected r=%h z=%b il=%b lat=%0d rdy=0",
                         i, c, a, b, gr, gz, gil, glat, rdy, er, er == 32'd0, eil, elat);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
